// File: rtl/serial_7seg_chain_out_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_7seg_chain_out_pkg
// Brief   : Shared 7-segment decode table and display-driver state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package serial_7seg_chain_out_pkg;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  // The first element listed is index 15, the last is index 0.
  localparam logic [15:0][6:0] c_SEG7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Frame sequencer state encoding.
  localparam int          c_ST_W        = 3;
  localparam logic [2:0]  c_ST_IDLE     = 3'd0;
  localparam logic [2:0]  c_ST_LOAD     = 3'd1;
  localparam logic [2:0]  c_ST_SHIFT_LO = 3'd2;
  localparam logic [2:0]  c_ST_SHIFT_HI = 3'd3;
  localparam logic [2:0]  c_ST_LATCH    = 3'd4;
  localparam logic [2:0]  c_ST_DONE     = 3'd5;

endpackage
`default_nettype wire

// File: rtl/serial_7seg_chain_out_seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg7_hex_decode
// Brief   : Nibble + decimal point + blank -> segment byte {dp,g..a},
//           with optional common-anode inversion applied after blanking.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_hex_decode
  import serial_7seg_chain_out_pkg::*;
#(
  parameter int COMMON_ANODE = 0
) (
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  logic [7:0] w_active_high;

  // Blank wins over digit and dp; polarity flip is the very last step.
  always_comb begin
    w_active_high = i_blank ? 8'h00 : {i_dp, c_SEG7_TABLE[i_nibble]};
    o_seg         = (COMMON_ANODE != 0) ? ~w_active_high : w_active_high;
  end

endmodule
`default_nettype wire

// File: rtl/serial_7seg_chain_out.sv
`default_nettype none
// ============================================================================
// Module  : serial_7seg_chain_out
// Brief   : Drives a daisy-chain of 74HC595-style registers, one per 7-seg
//           digit: captures digits on a strobe, shifts an 8*N-bit frame with
//           a divided serial clock, then pulses the latch. A one-deep pending
//           buffer holds the newest update that arrives mid-frame.
// Revision: 1.0 - initial release
// ============================================================================
module serial_7seg_chain_out
  import serial_7seg_chain_out_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int CLK_DIV      = 4,
  parameter int MSB_FIRST    = 1,
  parameter int COMMON_ANODE = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_write_stb,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  output logic                    o_busy,
  output logic                    o_done_stb,
  output logic                    o_serial_data,
  output logic                    o_serial_clk,
  output logic                    o_serial_latch
);

  localparam int FRAME_W = 8 * NUM_DIGITS;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [c_ST_W-1:0]       r_state;
  logic [4*NUM_DIGITS-1:0] r_act_digits, r_pend_digits;
  logic [NUM_DIGITS-1:0]   r_act_dp,     r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank,  r_pend_blank;
  logic                    r_pending;
  logic [FRAME_W-1:0]      r_shift;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [DIV_W-1:0]        r_div_cnt;

  logic [FRAME_W-1:0]      w_frame;
  logic [CNT_W-1:0]        w_bit_idx;
  logic                    w_div_end;
  logic                    w_mid_frame;

  // One decoder per digit, feeding byte k of the frame.
  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      seg7_hex_decode #(
        .COMMON_ANODE (COMMON_ANODE)
      ) u_dec (
        .i_nibble (r_act_digits[4*k +: 4]),
        .i_dp     (r_act_dp[k]),
        .i_blank  (r_act_blank[k]),
        .o_seg    (w_frame[8*k +: 8])
      );
    end
  endgenerate

  // Bit counter runs 8N-1 down to 0; LSB-first order mirrors the index.
  always_comb begin
    w_bit_idx   = (MSB_FIRST != 0) ? r_bit_cnt : (c_LAST_BIT - r_bit_cnt);
    w_div_end   = (r_div_cnt == c_DIV_LAST);
    w_mid_frame = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
  end

  // Frame sequencer: buffers, shift register, bit and divider counters.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= c_ST_IDLE;
      r_act_digits <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (i_write_stb) begin
            r_act_digits <= i_digits;
            r_act_dp     <= i_dp;
            r_act_blank  <= i_blank;
            r_state      <= c_ST_LOAD;
          end
        end
        c_ST_LOAD: begin
          r_shift   <= w_frame;
          r_bit_cnt <= c_LAST_BIT;
          r_div_cnt <= '0;
          r_state   <= c_ST_SHIFT_LO;
        end
        c_ST_SHIFT_LO: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_state   <= c_ST_SHIFT_HI;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        c_ST_SHIFT_HI: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            if (r_bit_cnt == '0) begin
              r_state <= c_ST_LATCH;
            end else begin
              r_bit_cnt <= r_bit_cnt - CNT_W'(1);
              r_state   <= c_ST_SHIFT_LO;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        c_ST_LATCH: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_state   <= c_ST_DONE;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        c_ST_DONE: begin
          // A strobe landing on DONE is newer than anything pending.
          if (i_write_stb) begin
            r_act_digits <= i_digits;
            r_act_dp     <= i_dp;
            r_act_blank  <= i_blank;
            r_state      <= c_ST_LOAD;
          end else if (r_pending) begin
            r_act_digits <= r_pend_digits;
            r_act_dp     <= r_pend_dp;
            r_act_blank  <= r_pend_blank;
            r_state      <= c_ST_LOAD;
          end else begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Pending buffer: newest mid-frame strobe wins, consumed at DONE.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pending     <= 1'b0;
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_blank  <= '0;
    end else if (i_write_stb && w_mid_frame) begin
      r_pending     <= 1'b1;
      r_pend_digits <= i_digits;
      r_pend_dp     <= i_dp;
      r_pend_blank  <= i_blank;
    end else if (r_state == c_ST_DONE) begin
      r_pending <= 1'b0;
    end
  end

  // Registered outputs decoded from the current state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_busy         <= 1'b0;
      o_done_stb     <= 1'b0;
      o_serial_data  <= 1'b0;
      o_serial_clk   <= 1'b0;
      o_serial_latch <= 1'b0;
    end else begin
      o_busy         <= (r_state != c_ST_IDLE);
      o_done_stb     <= (r_state == c_ST_DONE);
      o_serial_clk   <= (r_state == c_ST_SHIFT_HI);
      o_serial_latch <= (r_state == c_ST_LATCH);
      o_serial_data  <= ((r_state == c_ST_SHIFT_LO) || (r_state == c_ST_SHIFT_HI) ||
                         (r_state == c_ST_LATCH)) ? r_shift[w_bit_idx] : 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/serial_7seg_chain_out.md
Name: serial_7seg_chain_out

Overview:
Parametrised driver for a daisy-chain of 74HC595-style shift registers, each feeding one 7-segment digit. On a write strobe it captures N BCD/hex digits plus per-digit decimal-point and blank flags, and decodes each digit to segments. It then shifts out an 8*N-bit frame with a programmable serial clock rate and pulses the latch. A one-deep pending buffer absorbs updates that arrive while a frame is in flight, so the clock/display core can strobe at any time.

Parameters:
NUM_DIGITS, 6, number of chained digits N (>=1)
CLK_DIV, 4, i_clk cycles per serial clock half-period (>=1)
MSB_FIRST, 1, 1: frame bit 8N-1 shifted first; 0: frame bit 0 first
COMMON_ANODE, 0, 1: invert all frame bits (segment on = 0)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_write_stb  in  1  one-cycle request to display current inputs
i_digits  in  4*N  digit k = i_digits[4k+3:4k], 0x0-0xF
i_dp  in  N  decimal point on for digit k
i_blank  in  N  digit k all segments off (dp included)
o_busy  out  1  frame in progress
o_done_stb  out  1  one-cycle pulse when frame latched
o_serial_data  out  1  shift data
o_serial_clk  out  1  shift clock, data stable at rising edge
o_serial_latch  out  1  storage-register latch, active high

Behaviour:
- Reset: state IDLE, pending flag and buffers cleared, all outputs 0. Reset mid-frame aborts immediately; no latch pulse.
- Segment byte seg(k) = {dp,g,f,e,d,c,b,a}. Hex decode of {g..a}: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. Blank forces 0x00. COMMON_ANODE inverts after blanking.
- Frame F[8N-1:0] = {seg(N-1),...,seg(0)}.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE + i_write_stb: capture inputs into the active buffer, go to LOAD.
- LOAD (1 cycle): decode into the shift register; bit counter = 8N-1.
- SHIFT_LO (CLK_DIV cycles): o_serial_data = current bit, sclk = 0.
- SHIFT_HI (CLK_DIV cycles): sclk = 1, data held. Then go to SHIFT_LO for the next bit, or to LATCH after the last bit.
- LATCH (CLK_DIV cycles): sclk = 0, latch = 1, data held at the last bit.
- DONE (1 cycle): o_done_stb = 1. Go to LOAD if pending is set (pending buffer becomes active, pending cleared), else IDLE. o_serial_data returns to 0 in IDLE.
- o_busy = 1 in every state except IDLE. Frame latency from the strobe cycle is 1 + 16*N*CLK_DIV + CLK_DIV + 1 cycles of busy (N=6, CLK_DIV=2: 196).
- i_write_stb while busy: capture inputs into the pending buffer and set pending. Later strobes overwrite the buffer, so the newest wins and only one extra frame is sent.
- i_write_stb in the same cycle as DONE: treated as pending, so LOAD follows directly.
- All outputs are registered; no combinational path from inputs to outputs.
- Inputs are sampled only on strobe cycles and may change freely otherwise.

Decomposition:
- Shared package: the segment decode constants (16-entry table) and the state encoding enum. Both are reused by the future multiplexed-display driver.
- One sub-module: seg7_hex_decode (combinational nibble + dp + blank + polarity -> 8 bits), instantiated per digit via generate.
- Timing counter, bit counter and FSM stay in the top module.

Test Plan:
1. Defaults with CLK_DIV=2, i_digits=0x123456, dp=0, blank=0, strobe -> 48 sclk rising edges. Bytes sampled in order 06,5B,4F,66,6D,7D, then one 2-cycle latch pulse and one o_done_stb. o_busy is high exactly 196 cycles.
2. COMMON_ANODE=1, i_digits=0x000008, blank[0]=1, dp[1]=1 -> last two bytes sampled are 0x3F inverted with dp (0x40), then 0xFF.
3. Strobe during frame (0x111111), then again (0x222222) before DONE -> exactly one extra frame, LOAD directly after DONE, contents 5B x6.
4. MSB_FIRST=0, i_digits=0xABCDEF -> first 8 bits sampled are 0x71 LSB-first (1,0,0,0,1,1,1,0).
5. Assert i_reset_n low at sclk edge 20 -> all outputs 0 asynchronously, no latch or done pulse. The next strobe produces a clean full frame.
6. N=1, CLK_DIV=1, i_digits=0xF -> 8 bits 0x71, 19 busy cycles.
